// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StPar   = 3'd3,
    StStop  = 3'd4,
    StErr   = 3'bxxx
  } uart_state_e;

  function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                             input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic int unsigned half_cycles(input int unsigned bit_len);
    return bit_len / 2;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud counter: clears on clr, flags the half-bit and full-bit points.
module uart_bit_timer #(
  parameter int unsigned BIT_CYCLES  = 16,
  parameter int unsigned HALF_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic half_done,
  output logic bit_done
);

  localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  logic [CW-1:0] count_q;

  assign half_done = (count_q == CW'(HALF_CYCLES - 1));
  assign bit_done  = (count_q == CW'(BIT_CYCLES - 1));

  // Self-wrap at a full bit so the counter can never run past BIT-1.
  always_ff @(posedge clk) begin
    if (reset || clr || bit_done) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 8 data bits LSB-first, one parity bit, one stop bit.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = 100_000_000,
  parameter int unsigned BAUD_RATE     = 19_200,
  parameter int unsigned PARITY        = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_strobe,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int unsigned BIT  = bit_cycles(CLK_FREQUENCY, BAUD_RATE);
  localparam int unsigned HALF = half_cycles(BIT);
  localparam int unsigned IW   = $clog2(DATA_BITS);

  uart_state_e          state_q, state_d;
  logic                 rx_meta_q, rxs;
  logic [DATA_BITS-1:0] shift_q;
  logic [IW-1:0]        idx_q;
  logic                 par_q;
  logic                 timer_clr, half_done, bit_done;
  logic                 start_ok, data_smp, par_smp, stop_smp;

  // Two-flop synchronizer, idle-high reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs       <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs       <= rx_meta_q;
    end
  end

  uart_bit_timer #(
    .BIT_CYCLES (BIT),
    .HALF_CYCLES(HALF)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (timer_clr),
    .half_done(half_done),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!rxs) state_d = StStart;
      StStart: if (half_done) state_d = rxs ? StIdle : StData;
      StData:  if (bit_done && idx_q == IW'(DATA_BITS - 1)) state_d = StPar;
      StPar:   if (bit_done) state_d = StStop;
      StStop:  if (bit_done) state_d = StIdle;
      default: state_d = StErr;
    endcase
  end

  always_comb begin
    busy      = (state_q != StIdle);
    start_ok  = (state_q == StStart) && half_done && !rxs;
    data_smp  = (state_q == StData) && bit_done;
    par_smp   = (state_q == StPar) && bit_done;
    stop_smp  = (state_q == StStop) && bit_done;
    timer_clr = (state_q == StIdle) || start_ok || data_smp || par_smp || stop_smp;
  end

  // The strobe cycle coincides with the return to idle, so busy drops with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q       <= '0;
      idx_q         <= '0;
      par_q         <= 1'b0;
      dout          <= '0;
      rx_strobe     <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      rx_strobe <= 1'b0;
      if (start_ok) begin
        idx_q <= '0;
      end
      if (data_smp) begin
        shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
        idx_q   <= idx_q + 1'b1;
      end
      if (par_smp) begin
        par_q <= rxs;
      end
      if (stop_smp) begin
        dout          <= shift_q;
        parity_error  <= ((^shift_q) ^ par_q) != 1'(PARITY);
        framing_error <= !rxs;
        rx_strobe     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at BIT=16, HALF=8.
module tb_uart_rx_core;

  localparam int BIT  = 16;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       rx_strobe, parity_error, framing_error, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int strobe_cnt = 0;
  int last_fall  = 0;

  logic [7:0] dq[$];
  logic       pq[$];
  logic       fq[$];
  logic       bq[$];
  int         tq[$];

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[4];

  uart_rx_core #(
    .CLK_FREQUENCY(1_600_000),
    .BAUD_RATE    (100_000),
    .PARITY       (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .dout         (dout),
    .rx_strobe    (rx_strobe),
    .parity_error (parity_error),
    .framing_error(framing_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (rx_strobe) begin
      dq.push_back(dout);
      pq.push_back(parity_error);
      fq.push_back(framing_error);
      bq.push_back(busy);
      tq.push_back(cyc);
      strobe_cnt = strobe_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sync_drv();
    @(posedge clk);
    #1;
  endtask

  // Caller must be aligned just after a rising edge.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    last_fall = cyc;
    for (int b = 0; b < 11; b++) begin
      rx = bits[b];
      repeat (BIT) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic wait_strobe(input int target, output bit ok);
    for (int i = 0; i < 400; i++) begin
      if (strobe_cnt >= target) break;
      @(negedge clk);
    end
    ok = (strobe_cnt >= target);
    check("strobe_arrived", 32'(ok), 32'd1);
  endtask

  initial begin
    int  cnt0;
    bit  ok;
    bit  saw_busy;

    vecs[0] = '{data: 8'h55, par: 1'b1, stop: 1'b1, exp_pe: 1'b0, exp_fe: 1'b0};
    vecs[1] = '{data: 8'hA3, par: 1'b0, stop: 1'b1, exp_pe: 1'b1, exp_fe: 1'b0};
    vecs[2] = '{data: 8'h0F, par: 1'b1, stop: 1'b0, exp_pe: 1'b0, exp_fe: 1'b1};
    vecs[3] = '{data: 8'h01, par: 1'b0, stop: 1'b1, exp_pe: 1'b0, exp_fe: 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dout", 32'(dout), 32'h00);
    check("reset_strobe", 32'(rx_strobe), 32'd0);
    check("reset_pe", 32'(parity_error), 32'd0);
    check("reset_fe", 32'(framing_error), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    sync_drv();
    reset = 1'b0;
    repeat (5) sync_drv();

    for (int i = 0; i < 4; i++) begin
      sync_drv();
      cnt0 = strobe_cnt;
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
      wait_strobe(cnt0 + 1, ok);
      repeat (20) @(negedge clk);
      check("vec_strobe_count", 32'(strobe_cnt), 32'(cnt0 + 1));
      if (ok) begin
        check("vec_dout", 32'(dq[cnt0]), 32'(vecs[i].data));
        check("vec_parity_error", 32'(pq[cnt0]), 32'(vecs[i].exp_pe));
        check("vec_framing_error", 32'(fq[cnt0]), 32'(vecs[i].exp_fe));
        check("vec_busy_at_strobe", 32'(bq[cnt0]), 32'd0);
        if (i == 0) begin
          check("latency", 32'(tq[cnt0] - last_fall), 32'(HALF + 10 * BIT + 3));
        end
      end
      check("vec_busy_after", 32'(busy), 32'd0);
    end

    // Short low glitch: a false start must not disturb the held outputs.
    sync_drv();
    cnt0 = strobe_cnt;
    saw_busy = 1'b0;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    check("glitch_busy_seen", 32'(saw_busy), 32'd1);
    check("glitch_no_strobe", 32'(strobe_cnt), 32'(cnt0));
    check("glitch_dout_held", 32'(dout), 32'h01);
    check("glitch_flags_held", 32'({parity_error, framing_error}), 32'd0);
    check("glitch_busy_after", 32'(busy), 32'd0);

    // Back-to-back frames with no idle bit in between.
    sync_drv();
    cnt0 = strobe_cnt;
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    wait_strobe(cnt0 + 2, ok);
    repeat (20) @(negedge clk);
    check("b2b_strobe_count", 32'(strobe_cnt), 32'(cnt0 + 2));
    if (ok) begin
      check("b2b_dout0", 32'(dq[cnt0]), 32'h00);
      check("b2b_dout1", 32'(dq[cnt0+1]), 32'hFF);
      check("b2b_flags0", 32'({pq[cnt0], fq[cnt0]}), 32'd0);
      check("b2b_flags1", 32'({pq[cnt0+1], fq[cnt0+1]}), 32'd0);
      check("b2b_spacing", 32'(tq[cnt0+1] - tq[cnt0]), 32'(11 * BIT));
    end

    // Reset in the middle of data bit 3 of 0x3C (LSB-first 0,0,1,1,...).
    sync_drv();
    cnt0 = strobe_cnt;
    rx = 1'b0;
    repeat (3 * BIT) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (BIT + HALF) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dout_cleared", 32'(dout), 32'h00);
    repeat (200) @(negedge clk);
    check("rst_no_strobe", 32'(strobe_cnt), 32'(cnt0));
    check("rst_idle_busy", 32'(busy), 32'd0);

    sync_drv();
    cnt0 = strobe_cnt;
    send_frame(8'h3C, 1'b1, 1'b1);
    wait_strobe(cnt0 + 1, ok);
    repeat (20) @(negedge clk);
    check("post_rst_count", 32'(strobe_cnt), 32'(cnt0 + 1));
    if (ok) begin
      check("post_rst_dout", 32'(dq[cnt0]), 32'h3C);
      check("post_rst_flags", 32'({pq[cnt0], fq[cnt0]}), 32'd0);
    end
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
